// File: rtl/murmur_chunker_pkg.sv
// Shared types and helpers for the Murmur chunk packer: widths, FSM states,
// the chunk payload, and byte-masking utilities.
package murmur_chunker_pkg;

  localparam int unsigned CHUNK_W         = 128;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned WORDS_PER_CHUNK = 4;
  localparam int unsigned BYTES_W         = 5;
  localparam int unsigned LEN_W           = 32;
  localparam int unsigned IDX_W           = 2;
  localparam int unsigned WBYTES_W        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [CHUNK_W-1:0] data;
    logic [BYTES_W-1:0] bytes;
    logic               last;
  } chunk_t;

  // A last beat never claims more than a full word.
  function automatic logic [WBYTES_W-1:0] clamp_bytes(input logic [WBYTES_W-1:0] nb);
    return (nb > WBYTES_W'(4)) ? WBYTES_W'(4) : nb;
  endfunction

  // Zero every byte lane at or above nb.
  function automatic logic [WORD_W-1:0] mask_word(input logic [WORD_W-1:0] w,
                                                  input logic [WBYTES_W-1:0] nb);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (WBYTES_W'(i) < nb) m[8*i +: 8] = w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/murmur_chunk_outreg.sv
// Single-entry output holding register for finished chunks; loads whenever
// it is empty or being drained in the same cycle.
module murmur_chunk_outreg
  import murmur_chunker_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  chunk_t           load_chunk,
  input  logic [LEN_W-1:0] load_len,
  output logic             free_c,
  input  logic             ready,
  output logic             valid,
  output chunk_t           chunk,
  output logic [LEN_W-1:0] len
);

  assign free_c = !valid || ready;

  // Contents only change when free, so a stalled chunk stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      chunk <= '0;
      len   <= '0;
    end else if (free_c) begin
      valid <= load;
      if (load) begin
        chunk <= load_chunk;
        len   <= load_len;
      end
    end
  end

endmodule

// File: rtl/murmur_chunker.sv
// Packs a 32-bit word stream into 128-bit hasher chunks, tracking message
// byte length and flagging the final (possibly partial) chunk.
module murmur_chunker
  import murmur_chunker_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WORD_W-1:0]   in_data_i,
  input  logic                in_last_i,
  input  logic [WBYTES_W-1:0] in_bytes_i,
  output logic                chunk_valid_o,
  input  logic                chunk_ready_i,
  output logic [CHUNK_W-1:0]  chunk_data_o,
  output logic [BYTES_W-1:0]  chunk_bytes_o,
  output logic                chunk_last_o,
  output logic [LEN_W-1:0]    msg_len_o
);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CHUNK_W-1:0] asm_data;
  logic [BYTES_W-1:0] asm_bytes;
  logic               hold_last;
  logic [LEN_W-1:0]   len;
  logic               accept_en;

  logic [WBYTES_W-1:0] word_bytes_c;
  logic [WORD_W-1:0]   word_c;
  logic [CHUNK_W-1:0]  asm_next_c;
  logic [BYTES_W-1:0]  bytes_next_c;
  logic [LEN_W-1:0]    len_next_c;
  logic                accept_c;
  logic                complete_c;
  logic                load_c;
  logic                free_c;
  chunk_t              load_chunk_c;
  logic [LEN_W-1:0]    load_len_c;
  chunk_t              out_chunk;

  // Incoming word merged into the assembly buffer at slot idx.
  always_comb begin
    word_bytes_c = in_last_i ? clamp_bytes(in_bytes_i) : WBYTES_W'(4);
    word_c       = mask_word(in_data_i, word_bytes_c);
    asm_next_c   = asm_data;
    for (int k = 0; k < int'(WORDS_PER_CHUNK); k++) begin
      if (idx == IDX_W'(k)) asm_next_c[WORD_W*k +: WORD_W] = word_c;
    end
    bytes_next_c = asm_bytes + BYTES_W'(word_bytes_c);
    len_next_c   = len + LEN_W'(word_bytes_c);
    accept_c     = (state == FILL) && in_valid_i;
    complete_c   = accept_c && (in_last_i || (idx == IDX_W'(WORDS_PER_CHUNK - 1)));
  end

  // HOLD replays the parked buffer; otherwise the completing beat goes straight out.
  always_comb begin
    load_c       = complete_c || (state == HOLD);
    load_chunk_c = '0;
    load_len_c   = len_next_c;
    if (state == HOLD) begin
      load_chunk_c.data  = asm_data;
      load_chunk_c.bytes = asm_bytes;
      load_chunk_c.last  = hold_last;
      load_len_c         = len;
    end else begin
      load_chunk_c.data  = asm_next_c;
      load_chunk_c.bytes = bytes_next_c;
      load_chunk_c.last  = in_last_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      asm_data  <= '0;
      asm_bytes <= '0;
      hold_last <= 1'b0;
      len       <= '0;
      accept_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= FILL;
            accept_en <= 1'b1;
            idx       <= '0;
            asm_data  <= '0;
            asm_bytes <= '0;
            len       <= '0;
          end
        end
        FILL: begin
          if (accept_c) begin
            len <= len_next_c;
            if (!complete_c) begin
              asm_data  <= asm_next_c;
              asm_bytes <= bytes_next_c;
              idx       <= idx + IDX_W'(1);
            end else if (free_c) begin
              asm_data  <= '0;
              asm_bytes <= '0;
              idx       <= '0;
              if (in_last_i) begin
                state     <= IDLE;
                accept_en <= 1'b0;
              end
            end else begin
              // Output still occupied: park the finished chunk in the buffer.
              asm_data  <= asm_next_c;
              asm_bytes <= bytes_next_c;
              hold_last <= in_last_i;
              idx       <= '0;
              state     <= HOLD;
              accept_en <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (free_c) begin
            asm_data  <= '0;
            asm_bytes <= '0;
            if (hold_last) begin
              state <= IDLE;
            end else begin
              state     <= FILL;
              accept_en <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          accept_en <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o = accept_en;

  murmur_chunk_outreg u_outreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_c),
    .load_chunk (load_chunk_c),
    .load_len   (load_len_c),
    .free_c     (free_c),
    .ready      (chunk_ready_i),
    .valid      (chunk_valid_o),
    .chunk      (out_chunk),
    .len        (msg_len_o)
  );

  assign chunk_data_o  = out_chunk.data;
  assign chunk_bytes_o = out_chunk.bytes;
  assign chunk_last_o  = out_chunk.last;

endmodule

// File: tb/tb_murmur_chunker.sv
// Scoreboard bench for murmur_chunker: messages are modelled as byte strings
// cut into 16-byte chunks; a monitor compares every presented chunk.
module tb_murmur_chunker;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         chunk_valid;
  logic         chunk_ready;
  logic [127:0] chunk_data;
  logic [4:0]   chunk_bytes;
  logic         chunk_last;
  logic [31:0]  msg_len;

  always #5 clk = ~clk;

  murmur_chunker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .in_last_i     (in_last),
    .in_bytes_i    (in_bytes),
    .chunk_valid_o (chunk_valid),
    .chunk_ready_i (chunk_ready),
    .chunk_data_o  (chunk_data),
    .chunk_bytes_o (chunk_bytes),
    .chunk_last_o  (chunk_last),
    .msg_len_o     (msg_len)
  );

  typedef struct {
    logic [127:0] data;
    logic [4:0]   bytes;
    logic         last;
    logic [31:0]  len;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;
  logic [31:0] wq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: a message is a byte string; chunk c holds bytes 16c..16c+15.
  task automatic push_expect(input logic [7:0] msg[$]);
    int   total;
    int   nchunks;
    int   cnt;
    exp_t e;
    total   = msg.size();
    nchunks = (total == 0) ? 1 : (total + 15) / 16;
    for (int c = 0; c < nchunks; c++) begin
      e.data = '0;
      cnt    = 0;
      for (int i = 0; i < 16; i++) begin
        if (c * 16 + i < total) begin
          e.data[8*i +: 8] = msg[c * 16 + i];
          cnt++;
        end
      end
      e.bytes = 5'(cnt);
      e.last  = (c == nchunks - 1);
      e.len   = 32'(total);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL word_accept_timeout: in_ready=%b required 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 3'd0;
  endtask

  // stall_after: check in_ready stays low for 10 cycles after that word, then release.
  // poke: pulse start after that word (must be ignored in FILL).
  task automatic send_msg(input logic [31:0] w[$], input logic [2:0] lb, input int gap_max,
                          input int stall_after, input int poke);
    logic [7:0]  bytes[$];
    logic [31:0] cur;
    int          nb;
    int          g;
    int          lastw;
    lastw = w.size() - 1;
    for (int i = 0; i <= lastw; i++) begin
      cur = w[i];
      nb  = (i == lastw) ? ((lb > 3'd4) ? 4 : int'(lb)) : 4;
      for (int b = 0; b < nb; b++) bytes.push_back(cur[8*b +: 8]);
    end
    push_expect(bytes);
    do_start();
    for (int i = 0; i <= lastw; i++) begin
      g = $urandom_range(0, gap_max);
      repeat (g) begin @(posedge clk); #1; end
      send_word(w[i], i == lastw, (i == lastw) ? lb : 3'($urandom_range(0, 7)));
      if (stall_after != 0 && i == stall_after - 1) begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk("in_ready_during_stall", 128'(in_ready), 128'(0));
        end
        ready_mode = 0;
        @(posedge clk); #1;
      end
      if (poke != 0 && i == poke - 1) do_start();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending_chunks", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    chk({tag, "_chunk_valid"}, 128'(chunk_valid), 128'(0));
    chk({tag, "_chunk_data"}, chunk_data, 128'(0));
    chk({tag, "_chunk_bytes"}, 128'(chunk_bytes), 128'(0));
    chk({tag, "_chunk_last"}, 128'(chunk_last), 128'(0));
    chk({tag, "_msg_len"}, 128'(msg_len), 128'(0));
  endtask

  initial begin
    chunk_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       chunk_ready = 1'b1;
        1:       chunk_ready = ($urandom_range(0, 3) != 0);
        default: chunk_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every presented chunk must equal the scoreboard head, stalled or not.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && chunk_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_chunk: got data %h bytes %0d, required no chunk",
                   chunk_data, chunk_bytes);
        end else begin
          e = exp_q[0];
          chk("chunk_data", chunk_data, e.data);
          chk("chunk_bytes", 128'(chunk_bytes), 128'(e.bytes));
          chk("chunk_last", 128'(chunk_last), 128'(e.last));
          if (e.last) chk("msg_len", 128'(msg_len), 128'(e.len));
          if (chunk_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int nw;
    logic [2:0] lb;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_bytes = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two full chunks, then a short message and a zero-length one back to back.
    ready_mode = 0;
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    send_msg(wq, 3'd4, 0, 0, 0);
    wq.delete();
    wq.push_back(32'hAABBCCDD);
    wq.push_back(32'h11223344);
    send_msg(wq, 3'd3, 0, 0, 0);
    wq.delete();
    wq.push_back(32'hDEADBEEF);
    send_msg(wq, 3'd0, 0, 0, 0);
    wait_drain();

    // Downstream stall mid-stream: input must back off after the 8th word.
    ready_mode = 2;
    @(posedge clk); #1;
    wq.delete();
    for (int i = 0; i < 12; i++) wq.push_back($urandom);
    send_msg(wq, 3'd4, 0, 8, 0);
    wait_drain();

    // Words offered in IDLE must be refused.
    in_valid = 1'b1;
    in_data  = 32'hBAD0BAD0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // start during FILL ignored; oversize in_bytes clamped to 4.
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back($urandom);
    send_msg(wq, 3'd2, 1, 0, 2);
    wq.delete();
    wq.push_back(32'h01234567);
    wq.push_back(32'h89ABCDEF);
    send_msg(wq, 3'd7, 0, 0, 0);
    wait_drain();

    // Reset mid-message, then one clean 4-word message.
    do_start();
    send_word(32'h55555555, 1'b0, 3'd0);
    send_word(32'h66666666, 1'b0, 3'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midmsg_reset");
    @(posedge clk); #1;
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back($urandom);
    send_msg(wq, 3'd4, 0, 0, 0);
    wait_drain();

    // Random messages with random gaps and random downstream backpressure.
    ready_mode = 1;
    for (int m = 0; m < 30; m++) begin
      nw = $urandom_range(1, 12);
      lb = (nw == 1) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 7));
      wq.delete();
      for (int i = 0; i < nw; i++) wq.push_back($urandom);
      send_msg(wq, lb, 2, 0, 0);
      wait_drain();
    end

    ready_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("final_scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/murmur_chunker.md
# murmur_chunker

Upstream packing stage for the Murmur hash datapath. It accepts a message as a stream of 32-bit words with a valid/ready handshake and packs them into 128-bit chunks. The chunk word order matches the hasher's per-32-bit slicing. It also tracks the message byte length and flags the final, possibly partial, chunk so the downstream seed-chaining and finalization logic knows where the message ends.

## Interface
- No parameters; widths are fixed by the 128-bit hasher chunk.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start_i` in 1: one-cycle pulse that opens a message. Honoured only in IDLE.
- `in_valid_i` in 1: input word valid.
- `in_ready_o` out 1: input word accepted when `in_valid_i & in_ready_o`.
- `in_data_i` in 32: message word; byte 0 is `[7:0]`.
- `in_last_i` in 1: this word ends the message.
- `in_bytes_i` in 3: valid bytes in the word, 0..4. Sampled only with `in_last_i`; otherwise the word is treated as 4 bytes.
- `chunk_valid_o` out 1: chunk available.
- `chunk_ready_i` in 1: downstream takes the chunk when `chunk_valid_o & chunk_ready_i`.
- `chunk_data_o` out 128: word k at `[32k+31:32k]`.
- `chunk_bytes_o` out 5: valid bytes in the chunk, 0..16.
- `chunk_last_o` out 1: final chunk of the message.
- `msg_len_o` out 32: total message bytes, valid while `chunk_last_o`.

## Operation
- **States:**
  - IDLE: `in_ready_o=0`.
  - FILL: assembling a chunk.
  - HOLD: the assembly buffer is complete but the output register is occupied; `in_ready_o=0`.
- **Transitions:**
  - IDLE→FILL on `start_i`. This clears the word index, the assembly buffer and the length counter.
  - In FILL, each accepted word is written to slot `idx` (0..3), then `idx` increments.
  - The assembly buffer completes on the 4th word or on an `in_last_i` word.
  - On completion, the buffer moves to the output register if that register is empty or is being consumed in the same cycle. Otherwise the FSM enters HOLD and the move happens on the first cycle the output frees.
  - After a transfer carrying last, the FSM goes to IDLE; otherwise it returns to FILL with `idx=0`.
- **Data rules:**
  - Unfilled slots are zero.
  - In a partial last word, bytes at or above `in_bytes_i` are masked to zero.
  - `chunk_bytes_o` = 4×(full words) + `in_bytes_i` of the last word.
  - The length counter adds 4 per non-last word and `in_bytes_i` for the last word. It wraps modulo 2^32.
- **Boundary cases:**
  - A zero-length message is one beat with `in_last_i=1`, `in_bytes_i=0`. It yields a chunk of all zeros with `chunk_bytes_o=0`, `chunk_last_o=1`, `msg_len_o=0`.
  - A message of exactly 16·n bytes ends with a full chunk carrying last. No extra empty chunk is emitted.
  - `start_i` outside IDLE is ignored.
  - `in_bytes_i > 4` on a last beat is clamped to 4.
  - Output registers stay stable while `chunk_valid_o & !chunk_ready_i`.
- **Reset:** `rst_n=0` at any point, including mid-message, forces IDLE and clears the buffer, counters and output register. On the next edge all outputs are 0, including `in_ready_o` and `chunk_valid_o`.

## Timing
- `in_ready_o` is 1 in FILL and 0 in IDLE and HOLD. It is a registered-state decode and never depends combinationally on `in_valid_i`.
- Sustained throughput is 1 word/cycle, i.e. one chunk per 4 cycles, with `chunk_ready_i` held high.
- Latency: the completing word is accepted at edge t and `chunk_valid_o` is high after edge t (visible at cycle t+1).
- Back-to-back messages:
  - `start_i` may be asserted in the first IDLE cycle after the last chunk is transferred, while that chunk is still waiting in the output register.
  - The first word may arrive the cycle after `start_i`.
- `chunk_ready_i` may combinationally depend on `chunk_valid_o`. The output side has no other combinational paths.

## Structure
- Shared hash package holds:
  - `CHUNK_W=128`, `WORD_W=32`, `WORDS_PER_CHUNK=4`.
  - The state enum {IDLE, FILL, HOLD}.
  - A `chunk_t` struct {data, bytes, last}.
- One natural sub-module: `murmur_chunk_outreg`, the single-entry output holding register with the valid/ready skid logic. The FSM, assembly buffer and length counter stay in the top module.

## Test plan
- 8 words of 0x03020100, 0x07060504… with last=1 and bytes=4 on word 8 → two chunks. Chunk 1: last=0, bytes=16. Chunk 2: last=1, bytes=16, `msg_len_o`=32.
- Words 0xAABBCCDD, 0x11223344 (last, bytes=3) → one chunk: data = 0…0_00223344_AABBCCDD, bytes=7, last=1, len=7.
- Zero-length message (last, bytes=0) → data=0, bytes=0, last=1, len=0.
- `chunk_ready_i` held low for 10 cycles mid-stream → `in_ready_o` drops after the 8th word. Output data stays stable throughout. No words are lost after release.
- `rst_n` low for 1 cycle after 2 words → all outputs 0 next cycle. A new start and a 4-word message then yields exactly one clean chunk.
- `start_i` pulsed during FILL plus `in_valid_i` high in IDLE → no effect, no word accepted.
